oc8051_debug_fetch: RTL
=======================

# oc8051_debug_fetch

Loadable, multi-port debug instruction-fetch memory for the oc8051 verification harness. A small load FSM fills an internal byte-wide program image from a 32-bit word stream. The block then serves NPORT registered opcode-window lookups, one per tracked PC, plus a 32-bit cxrom read port. Each lookup has a per-port validity flag. The block sits beside the core and feeds the debug checker comparing the two program-counter streams.

## Interface
- ROMSIZE, 386, program image size in bytes (1..65535)
- NPORT, 2, number of independent PC lookup ports
- NBYTES, 3, opcode bytes returned per port (1..4)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- load_start  in  1  begin (or restart) image load
- load_valid  in  1  load_word present
- load_word  in  32  four image bytes, byte k = load_word[8k+7:8k]
- load_ready  out  1  block accepts load_word this cycle
- rom_ready  out  1  image fully loaded
- cxrom_rd  in  1  cxrom read request
- cxrom_addr  in  16  cxrom byte address
- cxrom_data_out  out  32  bytes addr..addr+3, little-endian
- cxrom_valid  out  1  cxrom_data_out valid this cycle
- pc  in  NPORT*16  lookup PCs, port i at [16i+15:16i]
- op_out  out  NPORT*NBYTES*8  port i byte j at [(i*NBYTES+j)*8 +: 8] = image[pc_i+j]
- op_valid  out  NPORT  per-port window valid
- op_all_valid  out  1  AND of op_valid

## Operation
- Load FSM states:
  - IDLE: entered on reset. load_start -> LOAD with ptr=0.
  - LOAD: load_ready=1. Each load_valid&&load_ready writes bytes ptr..ptr+3 and sets ptr+=4. When the new ptr >= ROMSIZE -> DONE.
  - DONE: rom_ready=1. load_start -> LOAD with ptr=0 and rom_ready=0.
- load_start in LOAD restarts with ptr=0. A load_start and a word in the same cycle: the word is dropped and the restart wins.
- Image bytes with address >= ROMSIZE are discarded, so the final partial word only writes its in-range bytes.
- ptr is 17 bits wide and never wraps.
- Image memory is not cleared by reset or load_start. Contents are undefined until written.
- Lookup, per port i:
  - All address sums use 17-bit arithmetic. pc=16'hFFFF plus 1 is out of range and never aliases to address 0.
  - Byte j = image[pc_i+j] if pc_i+j < ROMSIZE, else 8'h00.
  - op_valid[i] = rom_ready && (pc_i + NBYTES <= ROMSIZE).
- cxrom: byte k = image[cxrom_addr+k] if in range, else 8'h00. This applies regardless of rom_ready.
- Image writes take priority over reads at the same address in the same cycle. Lookups return the pre-write byte.

## Timing
- Reset values: load_ready=0, rom_ready=0, cxrom_data_out=0, cxrom_valid=0, op_out=0, op_valid=0, op_all_valid=0. The FSM is in IDLE with ptr=0.
- Reset mid-load forces IDLE immediately and asynchronously. Partially written image bytes remain.
- Lookup latency is 1 cycle: pc sampled at edge n appears on op_out/op_valid after edge n.
- Lookups run every cycle with no handshake.
- cxrom latency is 1 cycle: cxrom_valid is high for exactly the cycle after cxrom_rd.
- cxrom_data_out holds its last value when cxrom_rd=0.
- rom_ready rises the cycle after the final accepted word. op_valid can first be 1 one cycle after that.
- load_ready falls in the same cycle as rom_ready rises.
- Full load takes ceil(ROMSIZE/4) accepted words. For 386 bytes that is 97 words, the last writing 2 bytes.

## Test plan
- Reset then load 97 words where byte value = addr[7:0]: rom_ready rises after word 97. load_ready=0 afterward. Extra load_valid is ignored.
- Set pc0=0, pc1=383 after load: next cycle port0 bytes {00,01,02} and valid=1; port1 bytes {7F,80,81} (addr 383..385) and valid=1. Then pc1=384: bytes {80,81,00}, op_valid[1]=0, op_all_valid=0.
- Set pc0=16'hFFFF: bytes all 00, op_valid[0]=0, with no alias to address 0.
- Assert cxrom_rd with addr=384: next cycle cxrom_valid=1 and data=32'h0000_8180. Idle cycles hold data with cxrom_valid=0.
- Pulse load_start in DONE: rom_ready=0 and op_valid=0 next cycle. Reload with inverted data, then confirm pc0=0 returns {FF,FE,FD}.
- Assert rst after 10 words: all outputs 0 asynchronously and the FSM is in IDLE. A following full load completes normally.

Source files
------------

// File: rtl/oc8051_debug_fetch.sv
// Loadable debug instruction-fetch image for the oc8051 harness: word-stream loader,
// NPORT registered opcode-window lookups and a 32-bit cxrom read port.
module oc8051_debug_fetch #(
    parameter int unsigned ROMSIZE = 386,
    parameter int unsigned NPORT   = 2,
    parameter int unsigned NBYTES  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_start,
    input  logic                        load_valid,
    input  logic [31:0]                 load_word,
    output logic                        load_ready,
    output logic                        rom_ready,
    input  logic                        cxrom_rd,
    input  logic [15:0]                 cxrom_addr,
    output logic [31:0]                 cxrom_data_out,
    output logic                        cxrom_valid,
    input  logic [NPORT*16-1:0]         pc,
    output logic [NPORT*NBYTES*8-1:0]   op_out,
    output logic [NPORT-1:0]            op_valid,
    output logic                        op_all_valid
);

    localparam int unsigned AW      = (ROMSIZE > 1) ? $clog2(ROMSIZE) : 1;
    localparam logic [16:0] ROM_END = 17'(ROMSIZE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [16:0] ptr_q, ptr_d;
    logic [16:0] ptr_inc;
    logic        wr_en;
    logic [16:0] wr_addr [4];

    logic [7:0]  mem [ROMSIZE];

    logic [NPORT*NBYTES*8-1:0] op_d;
    logic [NPORT-1:0]          op_valid_d;
    logic [31:0]               cx_d;

    assign load_ready   = (state_q == ST_LOAD);
    assign rom_ready    = (state_q == ST_DONE);
    assign op_all_valid = &op_valid;

    // A load_start in the same cycle as a word drops the word.
    assign wr_en   = load_ready && load_valid && !load_start;
    assign ptr_inc = ptr_q + 17'd4;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            wr_addr[k] = ptr_q + 17'(k);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    ptr_d = '0;
                end else if (load_valid) begin
                    ptr_d = ptr_inc;
                    if (ptr_inc >= ROM_END) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Image is deliberately outside reset so a reset mid-load keeps written bytes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_addr[k] < ROM_END) begin
                    mem[wr_addr[k][AW-1:0]] <= load_word[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        logic [16:0] a;
        logic [16:0] base;
        a          = '0;
        base       = '0;
        op_d       = '0;
        op_valid_d = '0;
        for (int i = 0; i < NPORT; i++) begin
            base = {1'b0, pc[16*i +: 16]};
            for (int j = 0; j < NBYTES; j++) begin
                a = base + 17'(j);
                if (a < ROM_END) begin
                    op_d[(i*NBYTES+j)*8 +: 8] = mem[a[AW-1:0]];
                end
            end
            // Suppressed on a restart edge so op_valid drops together with rom_ready.
            op_valid_d[i] = rom_ready && !load_start && ((base + 17'(NBYTES)) <= ROM_END);
        end
    end

    always_comb begin
        logic [16:0] a;
        a    = '0;
        cx_d = '0;
        for (int k = 0; k < 4; k++) begin
            a = {1'b0, cxrom_addr} + 17'(k);
            if (a < ROM_END) begin
                cx_d[8*k +: 8] = mem[a[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            op_out         <= '0;
            op_valid       <= '0;
            cxrom_valid    <= 1'b0;
            cxrom_data_out <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_out      <= op_d;
            op_valid    <= op_valid_d;
            cxrom_valid <= cxrom_rd;
            if (cxrom_rd) begin
                cxrom_data_out <= cx_d;
            end
        end
    end

endmodule
